// File: rtl/bcd_to_binary.sv
// bcd_to_binary: 4-digit packed-BCD to 14-bit unsigned binary converter.
// Reverse double-dabble, one shift-and-correct iteration per clock, with
// valid/ready handshakes on the input and result sides.
module bcd_to_binary (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  thousands,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  tens,
    input  logic [3:0]  ones,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] binary,
    output logic        err
);

    localparam int unsigned BIN_W     = 14;
    localparam int unsigned BCD_W     = 16;
    localparam int unsigned SHIFT_W   = BCD_W + BIN_W;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned LAST_ITER = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_W-1:0]     binary_q, binary_d;
    logic                 err_q, err_d;

    logic                 digit_bad;
    logic                 last_iter;
    logic [SHIFT_W-1:0]   shifted;
    logic [SHIFT_W-1:0]   corrected;

    // Undo the x2 carry bias of a BCD nibble that crossed into the upper half.
    function automatic logic [3:0] fix_nibble(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    assign digit_bad = (thousands > 4'd9) || (hundreds > 4'd9) ||
                       (tens > 4'd9) || (ones > 4'd9);
    assign last_iter = (cnt_q == CNT_W'(LAST_ITER));
    assign shifted   = {1'b0, shift_q[SHIFT_W-1:1]};
    assign corrected = {fix_nibble(shifted[29:26]), fix_nibble(shifted[25:22]),
                        fix_nibble(shifted[21:18]), fix_nibble(shifted[17:14]),
                        shifted[BIN_W-1:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = digit_bad ? DONE : CONV;
            CONV: if (last_iter) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: load on accept, shift-and-correct during CONV.
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (digit_bad) begin
                        err_d    = 1'b1;
                        binary_d = '0;
                    end else begin
                        shift_d = {thousands, hundreds, tens, ones, BIN_W'(0)};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            CONV: begin
                shift_d = corrected;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_iter) binary_d = corrected[BIN_W-1:0];
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            err_q    <= err_d;
        end
    end

    assign binary = binary_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  thousands = '0;
    logic [3:0]  hundreds = '0;
    logic [3:0]  tens = '0;
    logic [3:0]  ones = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [13:0] binary;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    bcd_to_binary dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .binary    (binary),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold in_valid until it is accepted.
    task automatic start(input logic [3:0] th, input logic [3:0] hu,
                         input logic [3:0] te, input logic [3:0] on,
                         input string tag);
        int guard;
        thousands = th; hundreds = hu; tens = te; ones = on;
        in_valid  = 1'b1;
        guard = 0;
        while (!in_ready && guard < 40) begin
            tick;
            guard++;
        end
        if (!in_ready) check({tag, " accept_timeout"}, 0, 1);
        tick;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid; latency counts the accepting edge as cycle 1.
    task automatic wait_done(input int exp_bin, input int exp_err,
                             input int exp_lat, input string tag);
        int guard;
        guard = 0;
        while (!out_valid && guard < 40) begin
            tick;
            guard++;
        end
        check({tag, " latency"}, out_valid ? (cyc - acc_cyc + 1) : -1, exp_lat);
        check({tag, " binary"}, int'(binary), exp_bin);
        check({tag, " err"}, int'(err), exp_err);
    endtask

    task automatic finish_xfer(input string tag);
        out_ready = 1'b1;
        tick;
        check({tag, " out_valid_drop"}, int'(out_valid), 0);
        check({tag, " in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        int bad;
        int last_out;

        // Reset
        repeat (3) tick;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset binary", int'(binary), 0);
        check("reset err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        // 0000
        out_ready = 1'b1;
        start(4'd0, 4'd0, 4'd0, 4'd0, "zero");
        wait_done(0, 0, 15, "zero");
        finish_xfer("zero");

        // 9999 and residual BCD field
        start(4'd9, 4'd9, 4'd9, 4'd9, "max");
        wait_done(9999, 0, 15, "max");
        check("max shifter_hi", int'(dut.shift_q[29:14]), 0);
        finish_xfer("max");

        // 1234 with digit toggles and in_valid pulses during CONV
        start(4'd1, 4'd2, 4'd3, 4'd4, "toggle");
        for (int i = 0; i < 6; i++) begin
            thousands = 4'd9; hundreds = 4'(i); tens = 4'hF; ones = 4'd7;
            in_valid  = (i % 2 == 0);
            tick;
        end
        in_valid = 1'b0;
        wait_done(1234, 0, 15, "toggle");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid) bad++;
        end
        check("toggle no_second_result", bad, 0);

        // Illegal digit then recovery
        start(4'd0, 4'd0, 4'hA, 4'd0, "illegal");
        wait_done(0, 1, 1, "illegal");
        finish_xfer("illegal");
        start(4'd0, 4'd0, 4'd4, 4'd2, "after_err");
        wait_done(42, 0, 15, "after_err");
        finish_xfer("after_err");

        // Backpressure hold
        out_ready = 1'b0;
        start(4'd0, 4'd5, 4'd0, 4'd8, "hold");
        wait_done(508, 0, 15, "hold");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (binary != 14'd508 || !out_valid || in_ready || err) bad++;
        end
        check("hold stable", bad, 0);
        finish_xfer("hold");

        // Reset mid-CONV
        start(4'd9, 4'd8, 4'd7, 4'd6, "midrst");
        repeat (6) tick;
        #2 rst = 1'b1;
        #1;
        check("midrst in_ready", int'(in_ready), 1);
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst binary", int'(binary), 0);
        check("midrst err", int'(err), 0);
        check("midrst shifter", (dut.shift_q == 30'd0) ? 1 : 0, 1);
        @(negedge clk);
        rst = 1'b0;
        tick;
        start(4'd0, 4'd0, 4'd0, 4'd1, "postrst");
        wait_done(1, 0, 15, "postrst");

        // Back-to-back sampled sweep
        out_ready = 1'b1;
        last_out  = -1;
        for (int v = 0; v < 10000; v += 7) begin
            start(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10),
                  $sformatf("sweep%0d", v));
            wait_done(v, 0, 15, $sformatf("sweep%0d", v));
            if (last_out >= 0) check($sformatf("sweep%0d spacing", v), cyc - last_out, 16);
            last_out = cyc;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
